// File: rtl/moving_sum_pkg.sv
// moving_sum_pkg
// Shared constants for the moving_sum boxcar accumulator. A package cannot
// see module parameters, so the derived sizes are exposed as constant
// functions of the parameters and evaluated by each user at elaboration.
//   win_f(log2_win)      window depth WIN = 2**LOG2_WIN
//   acc_w_f(n, log2_win) accumulator/output width ACC_W = N + LOG2_WIN
//   cnt_w_f(log2_win)    fill counter width LOG2_WIN + 1 (must hold WIN itself)
package moving_sum_pkg;

    function automatic int win_f(input int log2_win);
        return 1 << log2_win;
    endfunction

    function automatic int acc_w_f(input int n, input int log2_win);
        return n + log2_win;
    endfunction

    function automatic int cnt_w_f(input int log2_win);
        return log2_win + 1;
    endfunction

endpackage

// File: rtl/moving_sum_window.sv
// moving_sum_window
// WIN-deep, N-bit shift register with asynchronous active-low reset,
// synchronous clear and enable. Entry 0 holds the newest sample and entry
// WIN-1 the oldest, which is the sample that leaves on the next accept.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset, zeroes every entry
//   ce      shift in idata when high
//   clr     zero every entry (wins over ce)
//   idata   N-bit sample to shift in
//   oldest  N-bit entry accepted WIN enables earlier
module moving_sum_window
    import moving_sum_pkg::*;
#(
    parameter int N        = 8,
    parameter int LOG2_WIN = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         clr,
    input  logic [N-1:0] idata,
    output logic [N-1:0] oldest
);

    localparam int WIN = win_f(LOG2_WIN);

    logic [N-1:0] store [WIN];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIN; i++) store[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < WIN; i++) store[i] <= '0;
        end else if (ce) begin
            store[0] <= idata;
            for (int i = 1; i < WIN; i++) store[i] <= store[i-1];
        end
    end

    assign oldest = store[WIN-1];

endmodule

// File: rtl/moving_sum.sv
// moving_sum
// Streaming boxcar accumulator: keeps the exact sum of the last WIN accepted
// samples and presents it (raw sum, or truncating average when the
// MOVING_SUM_AVG_EN macro is defined) with a one-cycle valid strobe.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   ce      accept idata on this edge
//   clr     synchronous flush of window, sum, fill count and outputs
//   idata   N-bit unsigned sample
//   odata   N+LOG2_WIN-bit window sum or average, registered
//   ovalid  high for the cycle after an accept that left the window full
//   filled  level, WIN samples accepted since last reset/clr
// Build option: MOVING_SUM_AVG_EN selects odata = acc >> LOG2_WIN.
module moving_sum
    import moving_sum_pkg::*;
#(
    parameter int N        = 8,
    parameter int LOG2_WIN = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ce,
    input  logic                    clr,
    input  logic [N-1:0]            idata,
    output logic [N+LOG2_WIN-1:0]   odata,
    output logic                    ovalid,
    output logic                    filled
);

    localparam int WIN   = win_f(LOG2_WIN);
    localparam int ACC_W = acc_w_f(N, LOG2_WIN);
    localparam int CNT_W = cnt_w_f(LOG2_WIN);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIN);

    logic [N-1:0]     oldest;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    function automatic logic [ACC_W-1:0] out_fn(input logic [ACC_W-1:0] sum);
`ifdef MOVING_SUM_AVG_EN
        return sum >> LOG2_WIN;
`else
        return sum;
`endif
    endfunction

    moving_sum_window #(
        .N        (N),
        .LOG2_WIN (LOG2_WIN)
    ) u_window (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .clr    (clr),
        .idata  (idata),
        .oldest (oldest)
    );

    // acc + idata may exceed ACC_W transiently; the modular result after
    // subtracting oldest is still the exact window sum.
    always_comb begin
        acc_next   = acc + ACC_W'(idata) - ACC_W'(oldest);
        count_next = (count == CNT_FULL) ? count : count + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            count  <= '0;
            odata  <= '0;
            ovalid <= 1'b0;
        end else if (clr) begin
            acc    <= '0;
            count  <= '0;
            odata  <= '0;
            ovalid <= 1'b0;
        end else if (ce) begin
            acc    <= acc_next;
            count  <= count_next;
            odata  <= out_fn(acc_next);
            ovalid <= (count_next == CNT_FULL);
        end else begin
            ovalid <= 1'b0;
        end
    end

    assign filled = (count == CNT_FULL);

endmodule

// File: tb/tb_moving_sum.sv
// tb_moving_sum
// Directed bench for moving_sum with N=8, LOG2_WIN=3. Expected odata values
// are hand-derived window sums; exp_out maps them to the average when the
// MOVING_SUM_AVG_EN build is selected.
module tb_moving_sum;

    localparam int N        = 8;
    localparam int LOG2_WIN = 3;

    logic                  clk;
    logic                  rst_n;
    logic                  ce;
    logic                  clr;
    logic [N-1:0]          idata;
    logic [N+LOG2_WIN-1:0] odata;
    logic                  ovalid;
    logic                  filled;

    int checks = 0;
    int errors = 0;

    moving_sum #(
        .N        (N),
        .LOG2_WIN (LOG2_WIN)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .clr    (clr),
        .idata  (idata),
        .odata  (odata),
        .ovalid (ovalid),
        .filled (filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_out(input int sum);
`ifdef MOVING_SUM_AVG_EN
        return 32'(sum >> LOG2_WIN);
`else
        return 32'(sum);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Check all three outputs against an expected window sum and flags.
    task automatic check_all(input string tag, input int sum, input logic v, input logic f);
        check({tag, " odata"}, 32'(odata), exp_out(sum));
        check({tag, " ovalid"}, 32'(ovalid), 32'(v));
        check({tag, " filled"}, 32'(filled), 32'(f));
    endtask

    // Drive inputs, take one rising edge, settle to 1 time unit after it.
    task automatic step(input logic c, input logic cl, input int d);
        ce    = c;
        clr   = cl;
        idata = N'(d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        ce    = 1'b0;
        clr   = 1'b0;
        idata = '0;

        // Reset held, idle
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all("reset", 0, 1'b0, 1'b0);
        end
        rst_n = 1'b1;
        step(1'b0, 1'b0, 0);
        check_all("idle", 0, 1'b0, 1'b0);

        // Fill with 10
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 10);
            check_all("fill", 10 * k, k == 8, k == 8);
        end

        // Slide zeros through
        for (int j = 1; j <= 8; j++) begin
            step(1'b1, 1'b0, 0);
            check_all("slide", 80 - 10 * j, 1'b1, 1'b1);
        end

        // Maximum samples, no wrap
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, 1'b0, 255);
            check_all("max", (k < 8) ? 255 * k : 2040, 1'b1, 1'b1);
        end

        // Enable gaps
        step(1'b1, 1'b0, 1);
        check_all("gap acc1", 1786, 1'b1, 1'b1);
        step(1'b0, 1'b0, 77);
        check_all("gap hold1", 1786, 1'b0, 1'b1);
        step(1'b1, 1'b0, 2);
        check_all("gap acc2", 1533, 1'b1, 1'b1);
        step(1'b0, 1'b0, 77);
        check_all("gap hold2", 1533, 1'b0, 1'b1);

        // Clear with a competing sample; the 99 must be discarded
        step(1'b1, 1'b1, 99);
        check_all("clr", 0, 1'b0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 5);
            check_all("after clr", 5 * k, k == 8, k == 8);
        end

        // Asynchronous reset between edges
        ce = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_all("async rst", 0, 1'b0, 1'b0);
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 7);
            check_all("refill", 7 * k, k == 8, k == 8);
        end
        step(1'b1, 1'b0, 7);
        check_all("refill slide", 56, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
